// File: rtl/ss_restore_reader.sv
// Save-state restore: walks a DDR slot of tagged chunks and replays each word to its device on the ss bus.
// One DDR read in flight; a word is written one cycle after read data; stalls on ddr_busy and until ss_ack.
module ss_restore_reader #(
    parameter logic [31:0] SS_BASE     = 32'h3E00_0000,
    parameter logic [31:0] SLOT_SIZE   = 32'h0040_0000,
    parameter int          MAX_INDEX   = 17,
    parameter logic [31:0] MAX_WORDS   = 32'h0001_0000,
    parameter int          ACK_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  slot,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        ddr_acquire,
    output logic [31:0] ddr_addr,
    output logic        ddr_rd,
    input  logic        ddr_busy,
    input  logic [63:0] ddr_rdata,
    input  logic        ddr_rdata_ready,
    output logic        ss_restore,
    output logic [7:0]  ss_index,
    output logic [23:0] ss_addr,
    output logic [63:0] ss_data,
    output logic        ss_write,
    input  logic        ss_ack
);

    localparam int              ACK_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [23:0]     HDR_ID   = {16'h5353, 8'h00};
    localparam logic [7:0]      TERM_IDX = 8'hFF;
    localparam logic [7:0]      MAX_IDX8 = 8'(MAX_INDEX);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HDR,
        S_WAIT_HDR,
        S_RD_DATA,
        S_WAIT_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       ptr_q, ptr_d;
    logic [31:0]       end_q, end_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [7:0]        idx_q, idx_d;
    logic [23:0]       waddr_q, waddr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
    logic              error_q, error_d;

    logic [31:0] slot_base;
    logic [23:0] hdr_id;
    logic [7:0]  hdr_idx;
    logic [31:0] hdr_cnt;
    logic        hdr_bad;

    assign slot_base = SS_BASE + SLOT_SIZE * {30'd0, slot};
    assign hdr_id    = ddr_rdata[63:40];
    assign hdr_idx   = ddr_rdata[39:32];
    assign hdr_cnt   = ddr_rdata[31:0];
    // The reserved byte must be zero too, so it is folded into the magic compare.
    assign hdr_bad   = (hdr_id != HDR_ID)
                    || ((hdr_idx > MAX_IDX8) && (hdr_idx != TERM_IDX))
                    || (hdr_cnt > MAX_WORDS);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        end_d     = end_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        ack_cnt_d = ack_cnt_q;
        error_d   = error_q;
        ddr_rd    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = slot_base;
                    end_d   = slot_base + SLOT_SIZE;
                    error_d = 1'b0;
                    state_d = S_RD_HDR;
                end
            end
            S_RD_HDR, S_RD_DATA: begin
                if (ptr_q == end_q) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end else if (!ddr_busy) begin
                    ddr_rd  = 1'b1;
                    state_d = (state_q == S_RD_HDR) ? S_WAIT_HDR : S_WAIT_DATA;
                end
            end
            S_WAIT_HDR: begin
                if (ddr_rdata_ready) begin
                    ptr_d = ptr_q + 32'd8;
                    if (hdr_bad) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else if (hdr_idx == TERM_IDX) begin
                        state_d = S_DONE;
                    end else if (hdr_cnt == 32'd0) begin
                        state_d = S_RD_HDR;
                    end else begin
                        idx_d   = hdr_idx;
                        cnt_d   = hdr_cnt;
                        waddr_d = 24'd0;
                        state_d = S_RD_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (ddr_rdata_ready) begin
                    ptr_d     = ptr_q + 32'd8;
                    wdata_d   = ddr_rdata;
                    ack_cnt_d = '0;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (ss_ack) begin
                    waddr_d = waddr_q + 24'd1;
                    state_d = (({8'd0, waddr_q} + 32'd1) == cnt_q) ? S_RD_HDR : S_RD_DATA;
                end else if (ack_cnt_q == ACK_LAST) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            end_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            ack_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            end_q     <= end_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            ack_cnt_q <= ack_cnt_d;
            error_q   <= error_d;
        end
    end

    // DONE and ERROR are already outside the busy window.
    assign busy        = (state_q == S_RD_HDR) || (state_q == S_WAIT_HDR) || (state_q == S_RD_DATA)
                      || (state_q == S_WAIT_DATA) || (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);
    assign error       = error_q;
    assign ddr_acquire = busy;
    assign ss_restore  = busy;
    assign ddr_addr    = ptr_q;
    assign ss_index    = idx_q;
    assign ss_addr     = waddr_q;
    assign ss_data     = wdata_q;
    assign ss_write    = (state_q == S_WRITE);

endmodule

// File: tb/tb_ss_restore_reader.sv
// Directed bench for ss_restore_reader: vector table of slot images plus timeout, reset and arbitration sequences.
module tb_ss_restore_reader;

    localparam int ACK_TO = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  slot = 2'd0;
    logic        busy, done, error, ddr_acquire, ddr_rd, ss_restore, ss_write;
    logic [31:0] ddr_addr;
    logic        ddr_busy = 1'b0;
    logic [63:0] ddr_rdata = '0;
    logic        ddr_rdata_ready = 1'b0;
    logic [7:0]  ss_index;
    logic [23:0] ss_addr;
    logic [63:0] ss_data;
    logic        ss_ack = 1'b0;

    ss_restore_reader #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clk(clk), .reset(reset), .start(start), .slot(slot),
        .busy(busy), .done(done), .error(error), .ddr_acquire(ddr_acquire),
        .ddr_addr(ddr_addr), .ddr_rd(ddr_rd), .ddr_busy(ddr_busy),
        .ddr_rdata(ddr_rdata), .ddr_rdata_ready(ddr_rdata_ready),
        .ss_restore(ss_restore), .ss_index(ss_index), .ss_addr(ss_addr),
        .ss_data(ss_data), .ss_write(ss_write), .ss_ack(ss_ack)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [logic [31:0]];
    logic [31:0] rd_q [$];
    logic [95:0] wr_q [$];
    int          done_cnt = 0;
    int          consec_rd = 0;
    int          done_busy = 0;
    bit          ack_en = 1'b1;
    int          nchk = 0;
    int          nerr = 0;

    // DDR responder (2-cycle read latency), device ack model and bus monitors.
    always begin : models
        int          pend;
        logic [31:0] pend_addr;
        logic        prev_rd;
        pend = 0;
        pend_addr = '0;
        prev_rd = 1'b0;
        forever begin
            @(posedge clk);
            if (ddr_rd && !reset) begin
                rd_q.push_back(ddr_addr);
                pend_addr = ddr_addr;
                pend = 2;
            end
            if (ss_write && ss_ack && !reset) wr_q.push_back({ss_index, ss_addr, ss_data});
            if (done) done_cnt++;
            if (done && busy) done_busy++;
            if (ddr_rd && prev_rd) consec_rd++;
            prev_rd = ddr_rd;
            @(negedge clk);
            ddr_rdata_ready = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    ddr_rdata_ready = 1'b1;
                    ddr_rdata = mem.exists(pend_addr) ? mem[pend_addr] : 64'h0;
                end
            end
            ss_ack = ack_en && ss_write;
        end
    end

    typedef struct packed {
        logic [1:0]       slot;
        logic [5:0][63:0] img;
        logic [7:0]       n_rd;
        logic [7:0]       n_wr;
        logic [7:0]       n_done;
        logic             err;
        logic [95:0]      wr_first;
        logic [95:0]      wr_last;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [63:0] hdr(input logic [7:0] idx, input logic [31:0] cnt);
        return {16'h5353, 8'h00, idx, cnt};
    endfunction

    function automatic logic [95:0] wr(input logic [7:0] idx, input logic [23:0] a, input logic [63:0] d);
        return {idx, a, d};
    endfunction

    function automatic logic [31:0] base_of(input logic [1:0] s);
        return 32'h3E00_0000 + 32'h0040_0000 * {30'd0, s};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] s);
        @(negedge clk);
        slot  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, {95'd0, ok}, 96'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic load(input logic [1:0] s, input logic [5:0][63:0] img);
        mem.delete();
        for (int k = 0; k < 6; k++) mem[base_of(s) + 32'(8 * k)] = img[k];
    endtask

    localparam logic [63:0] TERM = {16'h5353, 8'h00, 8'hFF, 32'd0};

    initial begin
        logic [63:0] d [8];
        logic [5:0][63:0] img;
        int r0, w0, c0, hi, nrd;
        bit rd_ok;

        for (int k = 0; k < 8; k++) d[k] = {32'hD0D0_0000 + 32'(k), 32'h1234_5670 + 32'(k * 17)};

        for (int i = 0; i < 6; i++) vecs[i] = '0;
        vecs[0].slot = 2'd0;
        vecs[0].img[0] = hdr(8'd1, 32'd2); vecs[0].img[1] = d[0]; vecs[0].img[2] = d[1];
        vecs[0].img[3] = hdr(8'd3, 32'd1); vecs[0].img[4] = d[2]; vecs[0].img[5] = TERM;
        vecs[0].n_rd = 8'd6; vecs[0].n_wr = 8'd3; vecs[0].n_done = 8'd1;
        vecs[0].wr_first = wr(8'd1, 24'd0, d[0]); vecs[0].wr_last = wr(8'd3, 24'd0, d[2]);

        vecs[1].slot = 2'd0;
        vecs[1].img[0] = {16'h1234, 8'h00, 8'd1, 32'd2}; vecs[1].img[1] = d[0];
        vecs[1].n_rd = 8'd1; vecs[1].err = 1'b1;

        vecs[2].slot = 2'd0;
        vecs[2].img[0] = hdr(8'd5, 32'd0); vecs[2].img[1] = hdr(8'd2, 32'd1);
        vecs[2].img[2] = d[3]; vecs[2].img[3] = TERM;
        vecs[2].n_rd = 8'd4; vecs[2].n_wr = 8'd1; vecs[2].n_done = 8'd1;
        vecs[2].wr_first = wr(8'd2, 24'd0, d[3]); vecs[2].wr_last = wr(8'd2, 24'd0, d[3]);

        vecs[3].slot = 2'd1;
        vecs[3].img[0] = hdr(8'd18, 32'd1); vecs[3].img[1] = d[4];
        vecs[3].n_rd = 8'd1; vecs[3].err = 1'b1;

        vecs[4].slot = 2'd0;
        vecs[4].img[0] = hdr(8'd1, 32'h0001_0001);
        vecs[4].n_rd = 8'd1; vecs[4].err = 1'b1;

        vecs[5].slot = 2'd3;
        vecs[5].img[0] = hdr(8'd17, 32'd2); vecs[5].img[1] = d[4]; vecs[5].img[2] = d[5];
        vecs[5].img[3] = TERM;
        vecs[5].n_rd = 8'd4; vecs[5].n_wr = 8'd2; vecs[5].n_done = 8'd1;
        vecs[5].wr_first = wr(8'd17, 24'd0, d[4]); vecs[5].wr_last = wr(8'd17, 24'd1, d[5]);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ctl", {89'd0, busy, done, error, ddr_acquire, ddr_rd, ss_restore, ss_write}, 96'd0);
        chk("rst_addr", {32'd0, ddr_addr, ss_index, ss_addr}, 96'd0);
        chk("rst_data", {32'd0, ss_data}, 96'd0);

        for (int v = 0; v < 6; v++) begin
            load(vecs[v].slot, vecs[v].img);
            r0 = rd_q.size(); w0 = wr_q.size(); c0 = done_cnt;
            do_start(vecs[v].slot);
            chk($sformatf("v%0d_busy", v), {93'd0, busy, ss_restore, ddr_acquire}, 96'h7);
            chk($sformatf("v%0d_err_clr", v), {95'd0, error}, 96'd0);
            wait_idle($sformatf("v%0d_finish", v));
            nrd = rd_q.size() - r0;
            chk($sformatf("v%0d_n_rd", v), 96'(nrd), 96'(vecs[v].n_rd));
            chk($sformatf("v%0d_n_wr", v), 96'(wr_q.size() - w0), 96'(vecs[v].n_wr));
            chk($sformatf("v%0d_n_done", v), 96'(done_cnt - c0), 96'(vecs[v].n_done));
            chk($sformatf("v%0d_error", v), {95'd0, error}, {95'd0, vecs[v].err});
            rd_ok = 1'b1;
            for (int k = 0; k < nrd; k++)
                if (rd_q[r0 + k] !== base_of(vecs[v].slot) + 32'(8 * k)) rd_ok = 1'b0;
            chk($sformatf("v%0d_rd_addr", v), {95'd0, rd_ok}, 96'd1);
            if (vecs[v].n_wr != 0 && wr_q.size() > w0) begin
                chk($sformatf("v%0d_wr_first", v), wr_q[w0], vecs[v].wr_first);
                chk($sformatf("v%0d_wr_last", v), wr_q[wr_q.size() - 1], vecs[v].wr_last);
            end
            if (v == 0 && wr_q.size() > w0 + 1) chk("v0_wr_mid", wr_q[w0 + 1], wr(8'd1, 24'd1, d[1]));
        end

        // Slot 2 with arbiter stalled; a second start while busy must be ignored.
        img = '0;
        img[0] = hdr(8'd1, 32'd1); img[1] = d[6]; img[2] = TERM;
        load(2'd2, img);
        r0 = rd_q.size(); w0 = wr_q.size(); c0 = done_cnt;
        ddr_busy = 1'b1;
        do_start(2'd2);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            slot  = (i == 3) ? 2'd0 : 2'd2;
            if (ddr_rd) hi++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("stall_no_rd", 96'(hi + rd_q.size() - r0), 96'd0);
        ddr_busy = 1'b0;
        #1;
        chk("stall_release_rd", {63'd0, ddr_rd, ddr_addr}, {63'd0, 1'b1, 32'h3E80_0000});
        wait_idle("stall_finish");
        chk("stall_n_rd", 96'(rd_q.size() - r0), 96'd3);
        chk("stall_first_addr", 96'(rd_q[r0]), 96'h3E80_0000);
        chk("stall_n_done", 96'(done_cnt - c0), 96'd1);
        if (wr_q.size() > w0) chk("stall_wr", wr_q[w0], wr(8'd1, 24'd0, d[6]));

        // Device never acks: error after ACK_TO cycles of ss_write.
        img = '0;
        img[0] = hdr(8'd4, 32'd1); img[1] = d[7]; img[2] = TERM;
        load(2'd0, img);
        w0 = wr_q.size(); c0 = done_cnt;
        ack_en = 1'b0;
        do_start(2'd0);
        for (int i = 0; i < 200 && !ss_write; i++) @(negedge clk);
        chk("to_wr_up", {95'd0, ss_write}, 96'd1);
        hi = 0;
        for (int i = 0; i < 5000 && ss_write; i++) begin
            hi++;
            @(negedge clk);
        end
        chk("to_write_cycles", 96'(hi), 96'(ACK_TO));
        chk("to_after", {93'd0, error, busy, ss_write}, 96'h4);
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("to_no_done_wr", 96'(done_cnt - c0 + wr_q.size() - w0), 96'd0);

        // Reset mid-chunk with a read outstanding; its late data must be ignored.
        load(2'd0, vecs[0].img);
        do_start(2'd0);
        w0 = wr_q.size();
        for (int i = 0; i < 200 && wr_q.size() == w0; i++) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (ddr_rd) break;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_ctl", {89'd0, busy, done, error, ddr_acquire, ddr_rd, ss_restore, ss_write}, 96'd0);
        chk("mid_rst_addr", {32'd0, ddr_addr, ss_index, ss_addr}, 96'd0);
        chk("mid_rst_data", {32'd0, ss_data}, 96'd0);
        r0 = rd_q.size(); w0 = wr_q.size();
        repeat (4) @(negedge clk);
        chk("mid_rst_stale", {94'd0, ss_write, busy}, 96'd0);
        chk("mid_rst_quiet", 96'(rd_q.size() - r0 + wr_q.size() - w0), 96'd0);
        c0 = done_cnt;
        do_start(2'd0);
        wait_idle("restart_finish");
        chk("restart_n_wr", 96'(wr_q.size() - w0), 96'd3);
        chk("restart_n_done", 96'(done_cnt - c0), 96'd1);
        chk("restart_error", {95'd0, error}, 96'd0);

        chk("rd_back_to_back", 96'(consec_rd), 96'd0);
        chk("done_while_busy", 96'(done_busy), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
